uart_frame_timer: RTL
=====================

Name: uart_frame_timer

Overview:
- Parametrised successor to the fixed-rate UART baud generator.
- Times one complete UART frame of 1 start bit, 5-8 data bits, an optional parity bit and 1 or 2 stop bits.
- The baud divisor is programmable at run time.
- Emits per-bit mid/end strobes, a bit index, a bit-type code and a frame-done pulse. Shared by the UART TX and RX paths on the bus-decode FPGA design.

Parameters:
- CNT_W, 16, width of the baud divisor and bit-period counter.
- MIN_DIV, 2, smallest accepted divisor; smaller programmed values are clamped up to this.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  frame start request; sampled only in IDLE
- abort  in  1  synchronous abort of the current frame
- baud_div  in  CNT_W  bit period minus 1, in clocks; latched at start
- data_bits  in  2  data length minus 5 (0 = 5 bits, 3 = 8 bits); latched at start
- parity_en  in  1  parity bit present; latched at start
- stop2  in  1  two stop bits when 1; latched at start
- busy  out  1  high while the frame is running
- bit_mid  out  1  one-cycle pulse at mid-bit
- bit_end  out  1  one-cycle pulse at end of bit
- frame_done  out  1  one-cycle pulse at end of the last stop bit
- bit_idx  out  4  current bit index within the frame; 0 = start bit
- bit_type  out  2  current bit type: 0 start, 1 data, 2 parity, 3 stop

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; latched config 0.
- Bit period and frame length:
  - P = max(baud_div, MIN_DIV) + 1 clocks per bit; clamp is applied at latch time.
  - Frame bit count T = 1 + (data_bits+5) + parity_en + (stop2 ? 2 : 1), giving a range of 7 to 12.
- State machine, IDLE <-> RUN:
  - IDLE -> RUN: start=1 and abort=0 latches the config and clears cnt and bit_idx. busy goes high the next cycle.
  - RUN: cnt counts 0..P-1 and wraps to 0. bit_idx increments on each wrap.
  - RUN -> IDLE: on the wrap when bit_idx==T-1, or when abort=1. busy drops the next cycle.
- Strobes are registered, asserted one cycle after their condition:
  - bit_mid: condition cnt == (P-1)>>1.
  - bit_end: condition cnt == P-1.
  - frame_done: asserted with the final bit_end only, and never on abort.
- First bit_mid occurs ((P-1)>>1)+2 cycles after the start cycle. Total frame time from the start cycle to frame_done is T*P+1 cycles.
- bit_type is decoded combinationally from bit_idx and the latched config:
  - 0 for index 0.
  - 1 for indices 1..N.
  - 2 for index N+1 when parity is enabled.
  - 3 for the remaining indices.
- bit_type and bit_idx hold 0 in IDLE.
- Boundary rules:
  - start while busy: ignored; no retrigger.
  - start and abort in the same cycle while IDLE: abort wins and the block stays IDLE.
  - Changes to baud_div, data_bits, parity_en or stop2 during RUN: no effect until the next start.
  - abort on the final wrap cycle: no frame_done is issued; the bit_end of that cycle is still issued.
  - Counter never exceeds P-1. No overflow is possible for CNT_W bits.
  - Back-to-back frames: start may be asserted in the cycle after frame_done; there is a minimum one IDLE cycle between frames.
  - rst_n asserted mid-frame: immediate return to the reset state; strobes clear asynchronously.

Optional Feature:
- Macro: UART_FRAME_OVS_EN.
- Defined:
  - Adds output port os_tick (1 bit).
  - A sub-counter runs 0..S-1 with S = max(P>>4, 1). It is cleared at every bit boundary and at start.
  - os_tick is a one-cycle registered pulse on each sub-counter wrap. It is inactive in IDLE.
  - Gives roughly 16 ticks per bit for RX majority sampling.
- Undefined: no os_tick port and no sub-counter logic. All other behaviour is identical.

Test Plan:
- Case 1, 8N1 frame: baud_div=9, data_bits=3, parity_en=0, stop2=0, pulse start -> busy for 100 cycles; 10 bit_end pulses spaced 10 cycles; bit_mid 5 cycles before each bit_end; single frame_done with the 10th bit_end; bit_type sequence 0,1x8,3.
- Case 2, 7E2 frame: baud_div=4, data_bits=2, parity_en=1, stop2=1 -> T=11, frame_done 56 cycles after start; bit_type at idx 8 = 2; idx 9-10 = 3.
- Case 3, divisor clamp: baud_div=0 -> P=3; 5N1 frame (data_bits=0) completes in 21 cycles; bit_mid occurs at cnt==1.
- Case 4, abort: abort at bit_idx 4 mid-bit -> busy low the next cycle, no frame_done; a new start 2 cycles later runs a full frame normally.
- Case 5, ignored inputs: start re-pulsed during RUN, baud_div changed mid-frame -> frame timing unchanged; same-cycle start+abort in IDLE -> stays IDLE.
- Case 6, mid-frame reset: rst_n pulsed low mid-frame -> all outputs 0 immediately. With UART_FRAME_OVS_EN and baud_div=159 -> 16 os_tick pulses per bit, spaced 10 cycles.

Source files
------------

// File: rtl/uart_frame_timer.sv
// UART frame timer: programmable bit period, per-bit mid/end strobes, bit index/type, frame-done pulse.
// Optional oversample tick output (os_tick) enabled by defining UART_FRAME_OVS_EN.
module uart_frame_timer #(
   parameter int CNT_W   = 16,
   parameter int MIN_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] baud_div,
   input  logic [1:0]       data_bits,
   input  logic             parity_en,
   input  logic             stop2,
   output logic             busy,
   output logic             bit_mid,
   output logic             bit_end,
   output logic             frame_done,
   output logic [3:0]       bit_idx,
   output logic [1:0]       bit_type
`ifdef UART_FRAME_OVS_EN
   ,
   output logic             os_tick
`endif
);

   // state | meaning
   // IDLE  | waiting for start, outputs quiet
   // RUN   | timing bits of the current frame
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [3:0]       idx_q, idx_d;
   logic [1:0]       dbits_q, dbits_d;
   logic             par_q, par_d;
   logic             stop2_q, stop2_d;
   logic             mid_q, mid_d;
   logic             end_q, end_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] div_clamp;
   logic [3:0]       last_idx;
   logic [3:0]       last_data;
   logic             wrap;
   logic             run;

   assign div_clamp = (baud_div < MIN_DIV_C) ? MIN_DIV_C : baud_div;
   assign last_data = 4'd5 + {2'b00, dbits_q};
   assign last_idx  = last_data + {3'b000, par_q} + 4'd1 + {3'b000, stop2_q};
   assign wrap      = (cnt_q == per_q);
   assign run       = (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      idx_d   = idx_q;
      dbits_d = dbits_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      mid_d   = 1'b0;
      end_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_RUN;
               per_d   = div_clamp;
               dbits_d = data_bits;
               par_d   = parity_en;
               stop2_d = stop2;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         default: begin
            mid_d = (cnt_q == (per_q >> 1));
            end_d = wrap;
            if (wrap) begin
               cnt_d = '0;
               idx_d = idx_q + 4'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (wrap && (idx_q == last_idx)) begin
               // an abort landing on the final wrap still gets its bit_end, but not frame_done
               done_d  = !abort;
               state_d = ST_IDLE;
               idx_d   = '0;
            end
            if (abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         idx_q   <= '0;
         dbits_q <= '0;
         par_q   <= 1'b0;
         stop2_q <= 1'b0;
         mid_q   <= 1'b0;
         end_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         idx_q   <= idx_d;
         dbits_q <= dbits_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         mid_q   <= mid_d;
         end_q   <= end_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      bit_type = 2'd3;
      if (idx_q == 4'd0)
         bit_type = 2'd0;
      else if (idx_q <= last_data)
         bit_type = 2'd1;
      else if (par_q && (idx_q == last_data + 4'd1))
         bit_type = 2'd2;
   end

   assign busy       = run;
   assign bit_mid    = mid_q;
   assign bit_end    = end_q;
   assign frame_done = done_q;
   assign bit_idx    = idx_q;

`ifdef UART_FRAME_OVS_EN
   logic [CNT_W-1:0] sub_q, sub_d;
   logic             tick_q, tick_d;
   logic [CNT_W:0]   p_full;
   logic [CNT_W:0]   s_full;
   logic [CNT_W:0]   s_m1;

   // S = max(P>>4, 1); sub-counter runs 0..S-1
   assign p_full = {1'b0, per_q} + 1'b1;
   assign s_full = p_full >> 4;
   assign s_m1   = (s_full == '0) ? '0 : s_full - 1'b1;

   always_comb begin
      sub_d  = '0;
      tick_d = 1'b0;
      if (run && !abort) begin
         tick_d = ({1'b0, sub_q} == s_m1);
         if (wrap || tick_d)
            sub_d = '0;
         else
            sub_d = sub_q + 1'b1;
      end else if (run) begin
         tick_d = ({1'b0, sub_q} == s_m1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         sub_q  <= sub_d;
         tick_q <= tick_d;
      end
   end

   assign os_tick = tick_q;
`endif

endmodule
